// File: rtl/gpio_controller_if.sv
// PicoBlaze port bus plus interrupt handshake between processor decode and gpio_controller.
interface gpio_controller_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/gpio_controller.sv
// Register-mapped controller for an 8-bit gpio_bit bank: direction/drive, input sync,
// programmable edge capture and a PicoBlaze interrupt with acknowledge.
module gpio_controller #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_controller_if.slave bus,
  output logic [7:0]       gpio_oen,
  output logic [7:0]       gpio_data_out,
  input  logic [7:0]       gpio_data_in
);

  localparam int unsigned DW = 8;

  localparam logic [2:0] OFF_DOUT = 3'd0;
  localparam logic [2:0] OFF_DIR  = 3'd1;
  localparam logic [2:0] OFF_DIN  = 3'd2;
  localparam logic [2:0] OFF_IEN  = 3'd3;
  localparam logic [2:0] OFF_POL  = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_SET  = 3'd6;
  localparam logic [2:0] OFF_CLR  = 3'd7;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t        state_q;
  logic [DW-1:0] dout_q, dir_q, ien_q, pol_q, stat_q;
  logic [DW-1:0] s1_q, s2_q, prev_q;
  logic [DW-1:0] in_port_q;
  logic          cap_q;

  logic          sel, wr;
  logic [2:0]    off;
  logic [DW-1:0] rise, fall, set_mask, w1c_mask, rd_data;
  logic          unused_rd;

  // Reads carry no side effects, so the read qualifier is not needed.
  assign unused_rd = bus.read_strobe;

  assign sel = (bus.port_id[7:3] == BASE_ADDR[7:3]);
  assign off = bus.port_id[2:0];
  assign wr  = bus.write_strobe & sel;

  // Edge capture: selected polarity, enabled, and only on input pins.
  assign rise     = s2_q & ~prev_q;
  assign fall     = ~s2_q & prev_q;
  assign set_mask = ((pol_q & rise) | (~pol_q & fall)) & ien_q & ~dir_q;
  assign w1c_mask = (wr && off == OFF_STAT) ? bus.out_port : DW'(0);

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (off)
        OFF_DOUT: rd_data = dout_q;
        OFF_DIR:  rd_data = dir_q;
        OFF_DIN:  rd_data = s2_q;
        OFF_IEN:  rd_data = ien_q;
        OFF_POL:  rd_data = pol_q;
        OFF_STAT: rd_data = stat_q;
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      dout_q    <= '0;
      dir_q     <= '0;
      ien_q     <= '0;
      pol_q     <= '0;
      stat_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      in_port_q <= '0;
      cap_q     <= 1'b0;
    end else begin
      s1_q      <= gpio_data_in;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      in_port_q <= rd_data;
      cap_q     <= |set_mask;

      if (wr) begin
        case (off)
          OFF_DOUT: dout_q <= bus.out_port;
          OFF_DIR:  dir_q  <= bus.out_port;
          OFF_IEN:  ien_q  <= bus.out_port;
          OFF_POL:  pol_q  <= bus.out_port;
          OFF_SET:  dout_q <= dout_q | bus.out_port;
          OFF_CLR:  dout_q <= dout_q & ~bus.out_port;
          default:  ;
        endcase
      end

      // New edges win over a same-cycle write-1-to-clear.
      stat_q <= (stat_q & ~w1c_mask) | set_mask;

      // An acknowledge is ignored while a capture is in flight toward the request.
      case (state_q)
        ST_IDLE: if (cap_q) state_q <= ST_REQ;
        ST_REQ:  if (bus.interrupt_ack && !cap_q && !(|set_mask)) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_port    = in_port_q;
  assign bus.interrupt  = (state_q == ST_REQ);
  assign gpio_oen       = dir_q;
  assign gpio_data_out  = dout_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed bench for gpio_controller: register access, input latency, edge capture,
// filtering, collisions and reset.
module tb_gpio_controller;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk;
  logic       reset_n;
  logic [7:0] gpio_oen, gpio_data_out, gpio_data_in;
  logic [7:0] d;
  int         tests, fails;

  gpio_controller_if bus();

  gpio_controller #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .gpio_oen      (gpio_oen),
    .gpio_data_out (gpio_data_out),
    .gpio_data_in  (gpio_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] data);
    @(negedge clk);
    bus.port_id      = BASE | {5'b0, off};
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic rd_addr(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    @(negedge clk);
    data            = bus.in_port;
    bus.read_strobe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] data);
    rd_addr(BASE | {5'b0, off}, data);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;

    // Reset held with strobes active.
    reset_n           = 1'b0;
    bus.port_id       = BASE | 8'h01;
    bus.out_port      = 8'hFF;
    bus.write_strobe  = 1'b1;
    bus.read_strobe   = 1'b1;
    bus.interrupt_ack = 1'b1;
    gpio_data_in      = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_oen", gpio_oen, 8'h00);
    check("rst_dout", gpio_data_out, 8'h00);
    check("rst_irq", 8'(bus.interrupt), 8'h00);
    check("rst_in_port", bus.in_port, 8'h00);
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;
    reset_n           = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd(3'(i), d);
      check("rst_read", d, 8'h00);
    end

    // Direction and drive, SET/CLR.
    wr(3'd1, 8'hF0);
    check("dir_oen", gpio_oen, 8'hF0);
    wr(3'd0, 8'hA5);
    check("dout_pin", gpio_data_out, 8'hA5);
    wr(3'd6, 8'h0A);
    check("set_dout", gpio_data_out, 8'hAF);
    wr(3'd7, 8'hA0);
    check("clr_dout", gpio_data_out, 8'h0F);
    rd(3'd0, d);
    check("rd_dout", d, 8'h0F);
    rd(3'd1, d);
    check("rd_dir", d, 8'hF0);
    rd(3'd6, d);
    check("rd_set_zero", d, 8'h00);
    rd(3'd2, d);
    wr(3'd2, 8'hFF);
    rd(3'd2, d);
    check("din_ro", d, 8'h00);
    rd_addr(8'h00, d);
    check("unselected", d, 8'h00);

    // Input read latency.
    @(negedge clk);
    gpio_data_in = 8'h3C;
    bus.port_id  = BASE | 8'h02;
    repeat (3) @(negedge clk);
    check("din_latency", bus.in_port, 8'h3C);

    // Rising edge interrupt on bit 0, with in_port tracking STAT.
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h01);
    @(negedge clk);
    gpio_data_in = 8'h3D;
    bus.port_id  = BASE | 8'h05;
    repeat (3) @(negedge clk);
    check("irq_before_e3", 8'(bus.interrupt), 8'h00);
    check("stat_before_e2", bus.in_port, 8'h00);
    @(negedge clk);
    check("irq_at_e3", 8'(bus.interrupt), 8'h01);
    check("stat_at_e2", bus.in_port, 8'h01);
    ack_pulse();
    check("irq_acked", 8'(bus.interrupt), 8'h00);
    wr(3'd5, 8'h01);
    rd(3'd5, d);
    check("stat_w1c", d, 8'h00);

    // Filtering: wrong polarity, disabled bit, output bit.
    @(negedge clk);
    gpio_data_in = 8'h3C;
    repeat (5) @(negedge clk);
    rd(3'd5, d);
    check("filt_pol", d, 8'h00);
    @(negedge clk);
    gpio_data_in = 8'h3E;
    repeat (5) @(negedge clk);
    rd(3'd5, d);
    check("filt_ien", d, 8'h00);
    wr(3'd3, 8'hFF);
    wr(3'd4, 8'hFF);
    wr(3'd1, 8'h80);
    @(negedge clk);
    gpio_data_in = 8'hBE;
    repeat (5) @(negedge clk);
    rd(3'd5, d);
    check("filt_dir", d, 8'h00);
    check("filt_irq", 8'(bus.interrupt), 8'h00);
    wr(3'd1, 8'h00);

    // New edge on bit 1 coincides with W1C of bit 1.
    @(negedge clk);
    gpio_data_in = 8'hBC;
    repeat (5) @(negedge clk);
    gpio_data_in = 8'hBE;
    repeat (2) @(negedge clk);
    bus.port_id      = BASE | 8'h05;
    bus.out_port     = 8'h02;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
    rd(3'd5, d);
    check("w1c_collision", d, 8'h02);
    check("w1c_coll_irq", 8'(bus.interrupt), 8'h01);

    // New edge on bit 2 coincides with interrupt_ack.
    @(negedge clk);
    gpio_data_in = 8'hBA;
    repeat (5) @(negedge clk);
    gpio_data_in = 8'hBE;
    repeat (2) @(negedge clk);
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    check("ack_coll_e2", 8'(bus.interrupt), 8'h01);
    @(negedge clk);
    check("ack_coll_e3", 8'(bus.interrupt), 8'h01);
    bus.interrupt_ack = 1'b0;
    rd(3'd5, d);
    check("ack_coll_stat", d, 8'h06);
    ack_pulse();
    check("ack_after_coll", 8'(bus.interrupt), 8'h00);

    // Reset while an interrupt is pending.
    @(negedge clk);
    gpio_data_in = 8'hB6;
    repeat (5) @(negedge clk);
    gpio_data_in = 8'hBE;
    repeat (5) @(negedge clk);
    check("pend_irq", 8'(bus.interrupt), 8'h01);
    rd(3'd5, d);
    check("pend_stat", d, 8'h0E);
    @(negedge clk);
    reset_n          = 1'b0;
    bus.port_id      = BASE | 8'h01;
    bus.out_port     = 8'hFF;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    check("mid_rst_irq", 8'(bus.interrupt), 8'h00);
    check("mid_rst_oen", gpio_oen, 8'h00);
    reset_n          = 1'b1;
    bus.write_strobe = 1'b0;
    rd(3'd5, d);
    check("mid_rst_stat", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
